// File: rtl/arch_ctrl.sv
// Phase sequencer for the two-layer network: forward/back propagation enables and commit/eval strobes.
// Optional ARCH_CTRL_CONTINUOUS_EN: TR held during COMMIT restarts training with no IDLE cycle.
module arch_ctrl #(
  parameter int unsigned FPH_CYC = 4,
  parameter int unsigned FPO_CYC = 4,
  parameter int unsigned BPO_CYC = 4,
  parameter int unsigned BPH_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic TR,
  input  logic VL,
  output logic FPH,
  output logic FPO,
  output logic BPO,
  output logic BPH,
  output logic S_Train,
  output logic S_Error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD_H  = 3'd1,
    FWD_O  = 3'd2,
    BWD_O  = 3'd3,
    BWD_H  = 3'd4,
    COMMIT = 3'd5,
    EVAL   = 3'd6
  } state_t;

  localparam logic [7:0] FPH_LD = 8'(FPH_CYC - 32'd1);
  localparam logic [7:0] FPO_LD = 8'(FPO_CYC - 32'd1);
  localparam logic [7:0] BPO_LD = 8'(BPO_CYC - 32'd1);
  localparam logic [7:0] BPH_LD = 8'(BPH_CYC - 32'd1);

  state_t     state_r, state_nxt;
  logic [7:0] cnt_r, cnt_nxt;
  logic       train_r, train_nxt;
  logic       cnt_zero_s;

  assign cnt_zero_s = (cnt_r == 8'd0);

  // State, phase counter and run mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      train_r <= 1'b1;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      train_r <= train_nxt;
    end
  end

  // Next-state, counter reload and mode latch
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    train_nxt = train_r;
    case (state_r)
      IDLE: begin
        if (TR) begin
          state_nxt = FWD_H;
          cnt_nxt   = FPH_LD;
          train_nxt = 1'b1;
        end else if (VL) begin
          state_nxt = FWD_H;
          cnt_nxt   = FPH_LD;
          train_nxt = 1'b0;
        end else begin
          cnt_nxt   = 8'd0;
        end
      end
      FWD_H: begin
        if (cnt_zero_s) begin
          state_nxt = FWD_O;
          cnt_nxt   = FPO_LD;
        end else begin
          cnt_nxt   = cnt_r - 8'd1;
        end
      end
      FWD_O: begin
        if (cnt_zero_s && train_r) begin
          state_nxt = BWD_O;
          cnt_nxt   = BPO_LD;
        end else if (cnt_zero_s) begin
          state_nxt = EVAL;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt   = cnt_r - 8'd1;
        end
      end
      BWD_O: begin
        if (cnt_zero_s) begin
          state_nxt = BWD_H;
          cnt_nxt   = BPH_LD;
        end else begin
          cnt_nxt   = cnt_r - 8'd1;
        end
      end
      BWD_H: begin
        if (cnt_zero_s) begin
          state_nxt = COMMIT;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt   = cnt_r - 8'd1;
        end
      end
      COMMIT: begin
`ifdef ARCH_CTRL_CONTINUOUS_EN
        if (TR) begin
          state_nxt = FWD_H;
          cnt_nxt   = FPH_LD;
          train_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
`else
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
`endif
      end
      EVAL: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        train_nxt = 1'b1;
      end
    endcase
  end

  // Moore output decode of the registered state
  always_comb begin
    FPH     = 1'b0;
    FPO     = 1'b0;
    BPO     = 1'b0;
    BPH     = 1'b0;
    S_Train = 1'b0;
    S_Error = 1'b0;
    case (state_r)
      FWD_H:   FPH     = 1'b1;
      FWD_O:   FPO     = 1'b1;
      BWD_O:   BPO     = 1'b1;
      BWD_H:   BPH     = 1'b1;
      COMMIT:  S_Train = 1'b1;
      EVAL:    S_Error = 1'b1;
      default: FPH     = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_arch_ctrl.sv
// Directed, table-driven bench for arch_ctrl: train/validate sequences, request filtering,
// asynchronous reset mid-run and back-to-back training with single-cycle phases.
module tb_arch_ctrl;

  typedef struct {
    logic       tr;
    logic       vl;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tr, vl, tr2;
  logic fph, fpo, bpo, bph, s_train, s_error;
  logic fph2, fpo2, bpo2, bph2, s_train2, s_error2;
  logic [5:0] outs, outs2;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  localparam logic [5:0] O_FPH = 6'b100000;
  localparam logic [5:0] O_FPO = 6'b010000;
  localparam logic [5:0] O_BPO = 6'b001000;
  localparam logic [5:0] O_BPH = 6'b000100;
  localparam logic [5:0] O_STR = 6'b000010;
  localparam logic [5:0] O_SER = 6'b000001;
  localparam logic [5:0] O_NON = 6'b000000;

  always #5 clk = ~clk;

  assign outs  = {fph, fpo, bpo, bph, s_train, s_error};
  assign outs2 = {fph2, fpo2, bpo2, bph2, s_train2, s_error2};

  arch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .TR(tr), .VL(vl),
    .FPH(fph), .FPO(fpo), .BPO(bpo), .BPH(bph),
    .S_Train(s_train), .S_Error(s_error)
  );

  arch_ctrl #(.FPH_CYC(1), .FPO_CYC(1), .BPO_CYC(1), .BPH_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .TR(tr2), .VL(1'b0),
    .FPH(fph2), .FPO(fpo2), .BPO(bpo2), .BPH(bph2),
    .S_Train(s_train2), .S_Error(s_error2)
  );

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b (FPH FPO BPO BPH S_Train S_Error)", name, act, exp);
    end
  endtask

  function automatic logic [5:0] train_exp(input int c);
    if (c >= 1 && c <= 4)        return O_FPH;
    else if (c >= 5 && c <= 8)   return O_FPO;
    else if (c >= 9 && c <= 12)  return O_BPO;
    else if (c >= 13 && c <= 16) return O_BPH;
    else if (c == 17)            return O_STR;
    else                         return O_NON;
  endfunction

  function automatic logic [5:0] val_exp(input int c);
    if (c >= 1 && c <= 4)      return O_FPH;
    else if (c >= 5 && c <= 8) return O_FPO;
    else if (c == 9)           return O_SER;
    else                       return O_NON;
  endfunction

  // index 0 is the cycle before edge 0; tr_x/vl_x add extra single-cycle pulses (-1 = none)
  task automatic add_train(input logic vl0, input int tr_x, input int vl_x);
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.tr  = (i == 0) || (i == tr_x);
      v.vl  = ((i == 0) && vl0) || (i == vl_x);
      v.exp = train_exp(i);
      vecs.push_back(v);
    end
  endtask

  task automatic add_val();
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.tr  = 1'b0;
      v.vl  = (i == 0);
      v.exp = val_exp(i);
      vecs.push_back(v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tr    = 1'b0;
    vl    = 1'b0;
    tr2   = 1'b0;

    add_train(1'b0, -1, -1);   // plain training run
    add_val();                 // validation run
    add_train(1'b1, -1, -1);   // TR and VL together: TR wins
    add_train(1'b0, 3, 6);     // requests during a run are ignored

    repeat (2) @(negedge clk);
    check("reset_outs", outs, O_NON);
    check("reset_outs1", outs2, O_NON);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_release", outs, O_NON);

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
      tr = vecs[i].tr;
      vl = vecs[i].vl;
    end

    // asynchronous reset in the middle of BPO
    @(negedge clk);
    tr = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      tr = 1'b0;
    end
    check("pre_reset_bpo", outs, O_BPO);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", outs, O_NON);
    repeat (2) @(negedge clk);
    check("held_in_reset", outs, O_NON);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", c), outs, O_NON);
    end

    // single-cycle phases with TR held high
    @(negedge clk);
    tr2 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      logic [5:0] e;
      int p;
`ifdef ARCH_CTRL_CONTINUOUS_EN
      p = (c - 1) % 5;
`else
      p = (c - 1) % 6;
`endif
      case (p)
        0:       e = O_FPH;
        1:       e = O_FPO;
        2:       e = O_BPO;
        3:       e = O_BPH;
        4:       e = O_STR;
        default: e = O_NON;
      endcase
      @(negedge clk);
      check($sformatf("cont_c%0d", c), outs2, e);
    end
    tr2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_ctrl.md
# arch_ctrl

Phase sequencer for the two-layer neural-network datapath. On a training request it steps the hidden and output neurons through forward propagation, back propagation and a weight-commit strobe. On a validation request it runs forward propagation only, then strobes error evaluation. It sits beside the hidden-layer (ReLU) and output-layer (sigmoid) neuron arrays and drives only their phase enables and the top-level status strobes; it carries no data.

## Interface
- `FPH_CYC`, default 4: cycles `FPH` is held high per run; legal range 1..255.
- `FPO_CYC`, default 4: cycles `FPO` is held high; 1..255.
- `BPO_CYC`, default 4: cycles `BPO` is held high; 1..255.
- `BPH_CYC`, default 4: cycles `BPH` is held high; 1..255.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `TR` in 1: training request, level-sampled in IDLE.
- `VL` in 1: validation request, level-sampled in IDLE.
- `FPH` out 1: hidden-layer forward-propagation enable.
- `FPO` out 1: output-layer forward-propagation enable.
- `BPO` out 1: output-layer back-propagation enable.
- `BPH` out 1: hidden-layer back-propagation enable.
- `S_Train` out 1: one-cycle weight-commit strobe at the end of a training run.
- `S_Error` out 1: one-cycle error-evaluation strobe at the end of a validation run.

## Operation
- States: IDLE, FWD_H, FWD_O, BWD_O, BWD_H, COMMIT, EVAL.
- Moore outputs, decoded from registered state only; at most one output is high in any cycle.
  - FWD_H drives `FPH`.
  - FWD_O drives `FPO`.
  - BWD_O drives `BPO`.
  - BWD_H drives `BPH`.
  - COMMIT drives `S_Train`.
  - EVAL drives `S_Error`.
  - IDLE drives nothing.
- From IDLE:
  - `TR`=1 → FWD_H in train mode.
  - Else `VL`=1 → FWD_H in validate mode.
  - Else remain in IDLE.
  - `TR` has priority when both are high.
- Train mode: FWD_H → FWD_O → BWD_O → BWD_H → COMMIT → IDLE.
- Validate mode: FWD_H → FWD_O → EVAL → IDLE.
- Each phase state lasts exactly its `*_CYC` parameter. A down-counter is loaded with `*_CYC-1` on entry and the state advances when the counter reads 0.
- COMMIT and EVAL each last exactly 1 cycle.
- Counter width is 8 bits.
- Mode is latched on leaving IDLE and held until the next return to IDLE.
- `TR`/`VL` activity outside IDLE is ignored: no queuing, no abort. A request still high on the cycle the FSM is back in IDLE starts a new run.

## Timing
- Reset: while `rst_n`=0, the FSM is in IDLE, the counter is 0, the mode is train, and every output is 0. This takes effect immediately and asynchronously, including mid-run. Release is synchronous to the next `clk` edge.
- Request latency: with `TR` high at edge k (FSM in IDLE), `FPH` is high from cycle k+1.
- Train run length: FPH_CYC+FPO_CYC+BPO_CYC+BPH_CYC+1 cycles, then at least 1 IDLE cycle (but see Configuration).
- Validate run length: FPH_CYC+FPO_CYC+1 cycles, then at least 1 IDLE cycle.
- Phase boundaries are gapless: the last cycle of one enable is followed directly by the first cycle of the next.

## Configuration
- Macro `ARCH_CTRL_CONTINUOUS_EN`.
- Defined: if `TR` is high during COMMIT, the FSM goes COMMIT → FWD_H in train mode directly, with no IDLE cycle. Back-to-back training therefore has a period of FPH_CYC+FPO_CYC+BPO_CYC+BPH_CYC+1. EVAL still returns to IDLE.
- Undefined: COMMIT and EVAL always return to IDLE for at least one cycle.

## Test plan
- Defaults; `TR` pulsed high for the cycle before edge 0 → `FPH` cycles 1–4, `FPO` 5–8, `BPO` 9–12, `BPH` 13–16, `S_Train` cycle 17, all outputs 0 at cycle 18.
- Defaults; `VL` pulsed → `FPH` cycles 1–4, `FPO` 5–8, `S_Error` cycle 9, all outputs 0 at cycle 10; `BPO`/`BPH`/`S_Train` never assert.
- `TR` and `VL` high together → full train sequence as in scenario 1; `S_Error` never asserts.
- `VL` pulsed at cycle 6 of a train run, and `TR` pulsed at cycle 3 → ignored; the run is identical to scenario 1; FSM idle at cycle 18.
- `rst_n` driven low asynchronously mid-cycle at cycle 10 (during `BPO`) → all outputs 0 immediately; after release with `TR`=0, outputs stay 0.
- `FPH_CYC`=`FPO_CYC`=`BPO_CYC`=`BPH_CYC`=1 with `TR` held high → macro undefined: `S_Train` at cycles 5, 11, 17 (period 6); macro defined: `S_Train` at cycles 5, 10, 15 (period 5).
